// File: rtl/uart_tx_arbiter_if.sv
// Stream bundle between two packet requesters, the arbiter and the UART TX.
// Signal directions and suffixes are named from the arbiter's point of view.
interface uart_tx_arbiter_if #(
    parameter int unsigned WIDTH_P = 8
);
    logic               s0_valid_i;
    logic               s0_last_i;
    logic [WIDTH_P-1:0] s0_data_i;
    logic               s0_ready_o;

    logic               s1_valid_i;
    logic               s1_last_i;
    logic [WIDTH_P-1:0] s1_data_i;
    logic               s1_ready_o;

    logic               m_valid_o;
    logic               m_last_o;
    logic [WIDTH_P-1:0] m_data_o;
    logic               m_ready_i;

    // Arbiter side
    modport slave (
        input  s0_valid_i, s0_last_i, s0_data_i,
        output s0_ready_o,
        input  s1_valid_i, s1_last_i, s1_data_i,
        output s1_ready_o,
        output m_valid_o, m_last_o, m_data_o,
        input  m_ready_i
    );

    // Requester / UART TX side
    modport master (
        output s0_valid_i, s0_last_i, s0_data_i,
        input  s0_ready_o,
        output s1_valid_i, s1_last_i, s1_data_i,
        input  s1_ready_o,
        input  m_valid_o, m_last_o, m_data_o,
        output m_ready_i
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX stream between two requesters.
// Define UART_TX_ARB_HEADER_EN to prefix each packet with a source header byte.
module uart_tx_arbiter #(
    parameter int unsigned         WIDTH_P    = 8,
    parameter logic [WIDTH_P-1:0]  HDR_BASE_P = WIDTH_P'(8'hA0)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    uart_tx_arbiter_if.slave       bus,
    output logic [1:0]             grant_o,
    output logic                   busy_o
);

`ifdef UART_TX_ARB_HEADER_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PASS = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_e;
`endif

    state_e       state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic         busy_q, busy_d;
    logic         last_grant_q, last_grant_d;

    logic               sel;
    logic               pick;
    logic               m_valid;
    logic               m_last;
    logic [WIDTH_P-1:0] m_data;
    logic               s0_ready;
    logic               s1_ready;

    // grant_q is one-hot while busy, so bit 1 doubles as the source index
    assign sel = grant_q[1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        pick         = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_data       = '0;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.s0_valid_i || bus.s1_valid_i) begin
                    // On a tie the requester not served last wins
                    pick = (bus.s0_valid_i && bus.s1_valid_i) ? ~last_grant_q
                                                              : bus.s1_valid_i;
                    grant_d      = pick ? 2'b10 : 2'b01;
                    busy_d       = 1'b1;
                    last_grant_d = pick;
`ifdef UART_TX_ARB_HEADER_EN
                    state_d      = HDR;
`else
                    state_d      = PASS;
`endif
                end
            end

`ifdef UART_TX_ARB_HEADER_EN
            HDR: begin
                m_valid = 1'b1;
                m_data  = HDR_BASE_P + WIDTH_P'(sel);
                if (bus.m_ready_i) begin
                    state_d = PASS;
                end
            end
`endif

            PASS: begin
                m_valid  = sel ? bus.s1_valid_i : bus.s0_valid_i;
                m_last   = sel ? bus.s1_last_i  : bus.s0_last_i;
                m_data   = sel ? bus.s1_data_i  : bus.s0_data_i;
                s0_ready = ~sel & bus.m_ready_i;
                s1_ready =  sel & bus.m_ready_i;
                if (m_valid && bus.m_ready_i && m_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.m_valid_o  = m_valid;
    assign bus.m_last_o   = m_last;
    assign bus.m_data_o   = m_data;
    assign bus.s0_ready_o = s0_ready;
    assign bus.s1_ready_o = s1_ready;
    assign grant_o        = grant_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter, header-aware via UART_TX_ARB_HEADER_EN.
module tb_uart_tx_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [1:0] grant_o;
    logic       busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_arbiter_if #(.WIDTH_P(8)) bus();

    uart_tx_arbiter #(
        .WIDTH_P    (8),
        .HDR_BASE_P (8'hA0)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // {m_valid, m_last, m_data, s0_ready, s1_ready, grant, busy}
    logic [14:0] obs;
    // {m_valid, s0_ready, s1_ready, grant, busy}
    logic [5:0]  ctl;
    assign obs = {bus.m_valid_o, bus.m_last_o, bus.m_data_o, bus.s0_ready_o,
                  bus.s1_ready_o, grant_o, busy_o};
    assign ctl = {bus.m_valid_o, bus.s0_ready_o, bus.s1_ready_o, grant_o, busy_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.s0_valid_i = 1'b0; bus.s0_last_i = 1'b0; bus.s0_data_i = '0;
        bus.s1_valid_i = 1'b0; bus.s1_last_i = 1'b0; bus.s1_data_i = '0;
        bus.m_ready_i  = 1'b0;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        idle_inputs();
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        idle_inputs();
        bus.s0_valid_i = 1'b1;
        bus.m_ready_i  = 1'b1;
        step();
        step();
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", ctl, 6'b0);
        end
        apply_reset();
    endtask

    task automatic test_single();
        logic [7:0]  beats [3] = '{8'h11, 8'h22, 8'h33};
        logic [14:0] exp;
        apply_reset();
        bus.s0_valid_i = 1'b1; bus.s0_data_i = beats[0]; bus.m_ready_i = 1'b1;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL single_idle: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        sample();
        exp = {1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 2'b01, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL single_hdr: got %h want %h", obs, exp);
        end
        step();
`endif
        for (int i = 0; i < 3; i++) begin
            bus.s0_data_i = beats[i];
            bus.s0_last_i = (i == 2);
            sample();
            exp = {1'b1, (i == 2), beats[i], 1'b1, 1'b0, 2'b01, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, obs, exp);
            end
            step();
        end
        bus.s0_valid_i = 1'b0; bus.s0_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL single_done: got %b want %b", ctl, 6'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d0 [2] = '{8'h01, 8'h02};
        logic [7:0]  d1 [2] = '{8'h81, 8'h82};
        logic [14:0] exp;
        apply_reset();
        bus.s0_valid_i = 1'b1; bus.s0_data_i = d0[0];
        bus.s1_valid_i = 1'b1; bus.s1_data_i = d1[0];
        bus.m_ready_i  = 1'b1;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL b2b_idle: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        sample();
        exp = {1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 2'b01, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_hdr0: got %h want %h", obs, exp);
        end
        step();
`endif
        for (int i = 0; i < 2; i++) begin
            bus.s0_data_i = d0[i]; bus.s0_last_i = (i == 1);
            sample();
            exp = {1'b1, (i == 1), d0[i], 1'b1, 1'b0, 2'b01, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_s0_beat%0d: got %h want %h", i, obs, exp);
            end
            step();
        end
        // s0 keeps requesting with its next packet
        bus.s0_data_i = 8'h03; bus.s0_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL b2b_gap: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        sample();
        exp = {1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 2'b10, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_hdr1: got %h want %h", obs, exp);
        end
        step();
`endif
        for (int i = 0; i < 2; i++) begin
            bus.s1_data_i = d1[i]; bus.s1_last_i = (i == 1);
            sample();
            exp = {1'b1, (i == 1), d1[i], 1'b0, 1'b1, 2'b10, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_s1_beat%0d: got %h want %h", i, obs, exp);
            end
            step();
        end
        bus.s1_data_i = 8'h83; bus.s1_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL b2b_gap2: got %b want %b", ctl, 6'b0);
        end
        step();
        sample();
        n_cmp++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL b2b_third_tie: got %b want %b", grant_o, 2'b01);
        end
        apply_reset();
    endtask

    task automatic test_holdoff();
        logic [7:0]  d0 [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
        logic [14:0] exp;
        apply_reset();
        bus.s0_valid_i = 1'b1; bus.s0_data_i = d0[0]; bus.m_ready_i = 1'b1;
        bus.s1_data_i  = 8'hEE; bus.s1_last_i = 1'b1;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL hold_idle: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        step();
`endif
        for (int i = 0; i < 4; i++) begin
            if (i == 1) bus.s1_valid_i = 1'b1;
            bus.s0_data_i = d0[i]; bus.s0_last_i = (i == 3);
            sample();
            exp = {1'b1, (i == 3), d0[i], 1'b1, 1'b0, 2'b01, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL hold_s0_beat%0d: got %h want %h", i, obs, exp);
            end
            step();
        end
        bus.s0_valid_i = 1'b0; bus.s0_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL hold_gap: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        step();
`endif
        sample();
        exp = {1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 2'b10, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL hold_s1_beat: got %h want %h", obs, exp);
        end
        step();
        bus.s1_valid_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL hold_done: got %b want %b", ctl, 6'b0);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  d0 [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
        logic [14:0] exp;
        int          idx;
        apply_reset();
        bus.s0_valid_i = 1'b1; bus.s0_data_i = d0[0]; bus.m_ready_i = 1'b1;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL stall_idle: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        step();
`endif
        idx = 0;
        for (int c = 0; c < 8 && idx < 4; c++) begin
            bus.m_ready_i = (c % 2 == 0);
            bus.s0_data_i = d0[idx];
            bus.s0_last_i = (idx == 3);
            sample();
            exp = {1'b1, (idx == 3), d0[idx], bus.m_ready_i, 1'b0, 2'b01, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL stall_cycle%0d: got %h want %h", c, obs, exp);
            end
            step();
            if (bus.m_ready_i) idx++;
        end
        bus.s0_valid_i = 1'b0; bus.s0_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL stall_done: got %b want %b", ctl, 6'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [14:0] exp;
        apply_reset();
        bus.s0_valid_i = 1'b1; bus.s0_data_i = 8'h61; bus.m_ready_i = 1'b1;
        step();
`ifdef UART_TX_ARB_HEADER_EN
        step();
`endif
        sample();
        exp = {1'b1, 1'b0, 8'h61, 1'b1, 1'b0, 2'b01, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL arst_pass: got %h want %h", obs, exp);
        end
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL arst_immediate: got %b want %b", ctl, 6'b0);
        end
        bus.s1_valid_i = 1'b1; bus.s1_data_i = 8'h71; bus.s1_last_i = 1'b1;
        #1 reset_i = 1'b0;
        step();
        sample();
        n_cmp++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL arst_tie: got %b want %b", grant_o, 2'b01);
        end
        apply_reset();
    endtask

    task automatic test_header();
        logic [14:0] exp;
        apply_reset();
        bus.s1_valid_i = 1'b1; bus.s1_data_i = 8'h5A; bus.s1_last_i = 1'b1;
        bus.m_ready_i  = 1'b1;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL hdr_idle: got %b want %b", ctl, 6'b0);
        end
        step();
`ifdef UART_TX_ARB_HEADER_EN
        sample();
        exp = {1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 2'b10, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL hdr_byte: got %h want %h", obs, exp);
        end
        step();
`endif
        sample();
        exp = {1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 2'b10, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL hdr_payload: got %h want %h", obs, exp);
        end
        step();
        bus.s1_valid_i = 1'b0; bus.s1_last_i = 1'b0;
        sample();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL hdr_done: got %b want %b", ctl, 6'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_holdoff();
        test_stall();
        test_async_reset();
        test_header();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
